// File: rtl/servo_position_ctrl_if.sv
// Target-load handshake for servo_position_ctrl: the master requests a seek target for one channel.
interface servo_position_ctrl_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned POS_W  = 8
) ();
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             tgt_valid;
  logic             tgt_ready;
  logic [CH_W-1:0]  tgt_ch;
  logic [POS_W-1:0] tgt_pos;

  modport master (
    output tgt_valid,
    output tgt_ch,
    output tgt_pos,
    input  tgt_ready
  );

  modport slave (
    input  tgt_valid,
    input  tgt_ch,
    input  tgt_pos,
    output tgt_ready
  );
endinterface

// File: rtl/servo_position_ctrl.sv
// Tick-paced multi-channel servo position controller: keypad jog plus ramped seek to a target,
// each channel held inside its own [MIN_POS, MAX_POS] window.
module servo_position_ctrl #(
  parameter int unsigned              NUM_CH   = 4,
  parameter int unsigned              POS_W    = 8,
  parameter int unsigned              TICK_DIV = 524288,
  parameter int unsigned              HOME     = 128,
  parameter logic [NUM_CH*POS_W-1:0]  MIN_POS  = {4{8'd1}},
  parameter logic [NUM_CH*POS_W-1:0]  MAX_POS  = {4{8'd255}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               action,
  servo_position_ctrl_if.slave     tgt,
  output logic [NUM_CH*POS_W-1:0]  location,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        at_min,
  output logic [NUM_CH-1:0]        at_max,
  output logic [7:0]               led_out
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  typedef enum logic {StIdle, StSeek} ch_state_e;

  logic [CNT_W-1:0] cnt_q;
  logic             tick;
  logic [7:0]       led_q;
  ch_state_e        state_q [NUM_CH];
  logic [POS_W-1:0] loc_q   [NUM_CH];
  logic [POS_W-1:0] tgt_q   [NUM_CH];

  logic [POS_W-1:0] min_a   [NUM_CH];
  logic [POS_W-1:0] max_a   [NUM_CH];
  logic [POS_W-1:0] home_a  [NUM_CH];

  logic              is_home;
  logic              code_ok;
  logic [NUM_CH-1:0] jog_fwd;
  logic [NUM_CH-1:0] jog_rev;

  logic              ready;
  logic              accept;
  logic [POS_W-1:0]  sel_min;
  logic [POS_W-1:0]  sel_max;
  logic [POS_W-1:0]  tgt_clamp;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  // Per-channel limits and clamped home position, all constant.
  always_comb begin
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      min_a[k] = MIN_POS[k*POS_W +: POS_W];
      max_a[k] = MAX_POS[k*POS_W +: POS_W];
      if (HOME < 32'(min_a[k])) begin
        home_a[k] = min_a[k];
      end else if (HOME > 32'(max_a[k])) begin
        home_a[k] = max_a[k];
      end else begin
        home_a[k] = POS_W'(HOME);
      end
    end
  end

  always_comb begin
    is_home = (action == 8'h48);
    code_ok = is_home || (action == 8'h30);
    jog_fwd = '0;
    jog_rev = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      jog_fwd[k] = (action == 8'(32'h31 + 2 * k));
      jog_rev[k] = (action == 8'(32'h32 + 2 * k));
      code_ok    = code_ok || jog_fwd[k] || jog_rev[k];
    end
  end

  // Out-of-range channel indices match no k, so ready stays low for them.
  always_comb begin
    ready   = 1'b0;
    sel_min = '0;
    sel_max = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(tgt.tgt_ch) == k) begin
        ready   = (state_q[k] == StIdle);
        sel_min = min_a[k];
        sel_max = max_a[k];
      end
    end
    if (tick && is_home) begin
      ready = 1'b0;
    end
    if (tgt.tgt_pos < sel_min) begin
      tgt_clamp = sel_min;
    end else if (tgt.tgt_pos > sel_max) begin
      tgt_clamp = sel_max;
    end else begin
      tgt_clamp = tgt.tgt_pos;
    end
  end

  assign tgt.tgt_ready = ready;
  assign accept        = tgt.tgt_valid && ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      led_q <= 8'h30;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        state_q[k] <= StIdle;
        loc_q[k]   <= home_a[k];
        tgt_q[k]   <= home_a[k];
      end
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick && code_ok) begin
        led_q <= action;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (accept && 32'(tgt.tgt_ch) == k) begin
          // A fresh target beats a same-cycle jog; stepping begins on the next tick.
          tgt_q[k]   <= tgt_clamp;
          state_q[k] <= StSeek;
        end else if (tick) begin
          if (is_home) begin
            tgt_q[k]   <= home_a[k];
            state_q[k] <= StSeek;
          end else if (jog_fwd[k]) begin
            if (loc_q[k] < max_a[k]) loc_q[k] <= loc_q[k] + POS_W'(1);
            state_q[k] <= StIdle;
          end else if (jog_rev[k]) begin
            if (loc_q[k] > min_a[k]) loc_q[k] <= loc_q[k] - POS_W'(1);
            state_q[k] <= StIdle;
          end else if (state_q[k] == StSeek) begin
            if (loc_q[k] == tgt_q[k]) begin
              state_q[k] <= StIdle;
            end else if (loc_q[k] < tgt_q[k]) begin
              loc_q[k] <= loc_q[k] + POS_W'(1);
              if (loc_q[k] + POS_W'(1) == tgt_q[k]) state_q[k] <= StIdle;
            end else begin
              loc_q[k] <= loc_q[k] - POS_W'(1);
              if (loc_q[k] - POS_W'(1) == tgt_q[k]) state_q[k] <= StIdle;
            end
          end
        end
      end
    end
  end

  always_comb begin
    location = '0;
    busy     = '0;
    at_min   = '0;
    at_max   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      location[k*POS_W +: POS_W] = loc_q[k];
      busy[k]   = (state_q[k] == StSeek);
      at_min[k] = (loc_q[k] == min_a[k]);
      at_max[k] = (loc_q[k] == max_a[k]);
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_servo_position_ctrl.sv
// Directed bench for servo_position_ctrl: jog, clamped seek, cancel, home ramp and async reset.
module tb_servo_position_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  action = 8'h30;
  logic [31:0] location;
  logic [3:0]  busy;
  logic [3:0]  at_min;
  logic [3:0]  at_max;
  logic [7:0]  led_out;

  int n_vec = 0;
  int n_err = 0;

  servo_position_ctrl_if #(.NUM_CH(4), .POS_W(8)) tgt_if ();

  servo_position_ctrl #(
    .NUM_CH   (4),
    .POS_W    (8),
    .TICK_DIV (4),
    .HOME     (128),
    .MIN_POS  ({8'd120, 8'd70, 8'd35, 8'd1}),
    .MAX_POS  ({8'd190, 8'd180, 8'd200, 8'd255})
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .action   (action),
    .tgt      (tgt_if.slave),
    .location (location),
    .busy     (busy),
    .at_min   (at_min),
    .at_max   (at_max),
    .led_out  (led_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] loc(input int k);
    return location[k*8 +: 8];
  endfunction

  // Ticks fall on every 4th posedge after reset release; land just past the tick edge.
  task automatic tick_wait(input int n);
    repeat (4 * n) @(posedge clk);
    #1;
  endtask

  task automatic load_target(input logic [1:0] ch, input logic [7:0] pos);
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_ch    = ch;
    tgt_if.tgt_pos   = pos;
    #1;
    check("tgt_ready_idle", 32'(tgt_if.tgt_ready), 32'd1);
    @(posedge clk);
    #1;
    tgt_if.tgt_valid = 1'b0;
    check("busy_after_accept", 32'(busy[ch]), 32'd1);
    check("tgt_ready_busy", 32'(tgt_if.tgt_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    tgt_if.tgt_valid = 1'b0;
    tgt_if.tgt_ch    = '0;
    tgt_if.tgt_pos   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // 1: reset state, then 20 idle cycles
    check("rst_loc", location, 32'h80808080);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_led", 32'(led_out), 32'h30);
    check("rst_limits", {at_max, at_min}, 32'h0);
    tick_wait(5);
    check("idle_loc", location, 32'h80808080);
    check("idle_led", 32'(led_out), 32'h30);

    // 2: forward jog ch1 saturates at 200
    action = 8'h33;
    tick_wait(71);
    check("jog_199", 32'(loc(1)), 32'd199);
    check("jog_not_max", 32'(at_max[1]), 32'd0);
    tick_wait(1);
    check("jog_200", 32'(loc(1)), 32'd200);
    check("jog_at_max", 32'(at_max[1]), 32'd1);
    tick_wait(8);
    check("jog_hold", 32'(loc(1)), 32'd200);
    check("jog_led", 32'(led_out), 32'h33);
    action = 8'h30;

    // 3: ch2 target 10 clamps to 70, 58-tick seek
    load_target(2'd2, 8'd10);
    check("seek_step1", 32'(loc(2)), 32'd127);
    tick_wait(56);
    check("seek_71", 32'(loc(2)), 32'd71);
    check("seek_busy", 32'(busy[2]), 32'd1);
    tick_wait(1);
    check("seek_70", 32'(loc(2)), 32'd70);
    check("seek_done", 32'(busy[2]), 32'd0);
    check("seek_at_min", 32'(at_min[2]), 32'd1);

    // 4: ch3 seek to 190 cancelled by reverse jog
    load_target(2'd3, 8'd250);
    tick_wait(4);
    check("ch3_133", 32'(loc(3)), 32'd133);
    action = 8'h38;
    tick_wait(1);
    check("cancel_loc", 32'(loc(3)), 32'd132);
    check("cancel_busy", 32'(busy[3]), 32'd0);
    tick_wait(13);
    check("rev_sat", 32'(loc(3)), 32'd120);
    check("rev_at_min", 32'(at_min[3]), 32'd1);
    action = 8'h30;

    // 5: HOME with a colliding target load on ch0
    repeat (3) @(posedge clk);
    #1;
    action           = 8'h48;
    tgt_if.tgt_valid = 1'b1;
    tgt_if.tgt_ch    = 2'd0;
    tgt_if.tgt_pos   = 8'd200;
    #1;
    check("home_blocks_ready", 32'(tgt_if.tgt_ready), 32'd0);
    @(posedge clk);
    #1;
    tgt_if.tgt_valid = 1'b0;
    action = 8'h30;
    check("home_busy", 32'(busy), 32'hF);
    check("home_no_step", location, {8'd120, 8'd70, 8'd200, 8'd128});
    check("home_led", 32'(led_out), 32'h48);
    tick_wait(1);
    check("home_ch0_idle", 32'(busy), 32'hE);
    check("home_ch0_loc", 32'(loc(0)), 32'd128);
    tick_wait(7);
    check("home_ch3_done", 32'(busy), 32'h6);
    tick_wait(50);
    check("home_ch2_done", 32'(busy), 32'h2);
    tick_wait(14);
    check("home_all_done", 32'(busy), 32'h0);
    check("home_all_loc", location, 32'h80808080);
    check("home_led_idle", 32'(led_out), 32'h30);

    // 6: async reset mid-seek, then invalid code
    load_target(2'd1, 8'd150);
    action = 8'h31;
    tick_wait(1);
    action = 8'h30;
    load_target(2'd2, 8'd150);
    tick_wait(2);
    check("pre_rst_busy", 32'(busy[2]), 32'd1);
    check("pre_rst_led", 32'(led_out), 32'h30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_loc", location, 32'h80808080);
    check("mid_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    action = 8'h5A;
    rst_n  = 1'b1;
    #1;
    tick_wait(5);
    check("bad_code_loc", location, 32'h80808080);
    check("bad_code_led", 32'(led_out), 32'h30);
    check("bad_code_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
